// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: block fill on miss, word select on hit.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STATS_EN.
module icache_controller #(
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ_EN,
    input  logic [ADDR_W-1:0]        PC_ADDR,
    output logic [31:0]              INSTRUCTION,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
    input  logic [127:0]             MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]              HIT_COUNT,
    output logic [15:0]              MISS_COUNT
`endif
);

    localparam int unsigned Blocks = 2 ** INDEX_W;
    localparam int unsigned BlkW   = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        StIdle,
        StMemRead,
        StUpdate
    } state_e;

    state_e state_q, state_d;

    logic [Blocks-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [Blocks];
    logic [127:0]      data_q [Blocks];

    logic [BlkW-1:0]   miss_addr_q, miss_addr_d;
    logic [127:0]      fill_q, fill_d;

    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] pc_idx;
    logic [INDEX_W-1:0] miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic [127:0]       cur_blk;
    logic               hit;

    // Byte offset bits never affect a word fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = ^PC_ADDR[1:0];

    assign pc_tag   = PC_ADDR[ADDR_W-1 -: TAG_W];
    assign pc_idx   = PC_ADDR[4 +: INDEX_W];
    assign miss_idx = miss_addr_q[INDEX_W-1:0];
    assign miss_tag = miss_addr_q[BlkW-1 -: TAG_W];
    assign cur_blk  = data_q[pc_idx];
    assign hit      = READ_EN && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    always_comb begin
        INSTRUCTION = 32'h0;
        if (hit) begin
            unique case (PC_ADDR[3:2])
                2'd0: INSTRUCTION = cur_blk[31:0];
                2'd1: INSTRUCTION = cur_blk[63:32];
                2'd2: INSTRUCTION = cur_blk[95:64];
                2'd3: INSTRUCTION = cur_blk[127:96];
                default: INSTRUCTION = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_d      = fill_q;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        unique case (state_q)
            StIdle: begin
                if (READ_EN && !hit) begin
                    BUSYWAIT    = 1'b1;
                    miss_addr_d = {pc_tag, pc_idx};
                    state_d     = StMemRead;
                end
            end
            StMemRead: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_addr_q;
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                BUSYWAIT = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StUpdate) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset; validity alone gates their use.
    always_ff @(posedge CLK) begin
        miss_addr_q <= miss_addr_d;
        fill_q      <= fill_d;
        if (!RESET && state_q == StUpdate) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StIdle && hit && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (state_q == StIdle && READ_EN && !hit && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= 16'h0;
            miss_cnt_q <= 16'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency block memory model.
module tb_icache_controller;

    localparam int Lat = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_en;
    logic [9:0]   pc_addr;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    icache_controller #(
        .TAG_W  (3),
        .INDEX_W(3),
        .ADDR_W (10)
    ) dut (
        .CLK         (clk),
        .RESET       (reset),
        .READ_EN     (read_en),
        .PC_ADDR     (pc_addr),
        .INSTRUCTION (instruction),
        .BUSYWAIT    (busywait),
        .MEM_READ    (mem_read),
        .MEM_ADDRESS (mem_address),
        .MEM_READDATA(mem_readdata),
        .MEM_BUSYWAIT(mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT   (hit_count),
        .MISS_COUNT  (miss_count)
`endif
    );

    // Memory: word w of block a is {a, w[7:0]}; data valid on the Lat-th request cycle.
    assign mem_busywait = mem_read && (mem_cnt != Lat - 1);
    assign mem_readdata = {{18'h0, mem_address, 8'h03}, {18'h0, mem_address, 8'h02},
                           {18'h0, mem_address, 8'h01}, {18'h0, mem_address, 8'h00}};

    always @(posedge clk) begin
        if (reset || !mem_read || !mem_busywait) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic re, input logic [9:0] pc);
        @(negedge clk);
        read_en = re;
        pc_addr = pc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        read_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Entered while sampling the miss-detect cycle; leaves on the first IDLE sample.
    task automatic fetch(input string tag, input logic [5:0] exp_addr, input logic sw,
                         input logic [9:0] alt_pc);
        int  n = 0;
        int  mr = 0;
        logic seen = 1'b0;
        logic done = 1'b0;
        logic [5:0] addr = '0;
        while (!done && n < 40) begin
            if (busywait) n++;
            if (mem_read) begin
                if (!seen) addr = mem_address;
                seen = 1'b1;
                mr++;
                if (sw && mr == 2) pc_addr = alt_pc;
            end else if (seen) begin
                done = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_done"}, {31'h0, done}, 32'h1);
        check_eq({tag, "_stall"}, n, 32'd7);
        check_eq({tag, "_mrcyc"}, mr, Lat);
        check_eq({tag, "_addr"}, {26'h0, addr}, {26'h0, exp_addr});
    endtask

    initial begin
        reset   = 1'b1;
        read_en = 1'b0;
        pc_addr = 10'h000;
        do_reset();
        check_eq("rst_busy", {31'h0, busywait}, 32'h0);
        check_eq("rst_mrd", {31'h0, mem_read}, 32'h0);
        check_eq("rst_maddr", {26'h0, mem_address}, 32'h0);
        check_eq("rst_instr", instruction, 32'h0);

        // Cold miss on block 0
        set_in(1'b1, 10'h000);
        check_eq("cold_busy", {31'h0, busywait}, 32'h1);
        fetch("f0", 6'h00, 1'b0, 10'h0);
        check_eq("f0_instr", instruction, 32'h0);
        check_eq("f0_busy", {31'h0, busywait}, 32'h0);

        set_in(1'b1, 10'h004);
        check_eq("w1", instruction, 32'h1);
        check_eq("w1_busy", {31'h0, busywait}, 32'h0);
        check_eq("w1_mrd", {31'h0, mem_read}, 32'h0);
        set_in(1'b1, 10'h008);
        check_eq("w2", instruction, 32'h2);
        check_eq("w2_busy", {31'h0, busywait}, 32'h0);
        set_in(1'b1, 10'h00C);
        check_eq("w3", instruction, 32'h3);
        check_eq("w3_busy", {31'h0, busywait}, 32'h0);
        check_eq("w3_mrd", {31'h0, mem_read}, 32'h0);

        // READ_EN low: idle outputs
        set_in(1'b0, 10'h004);
        check_eq("noreq_instr", instruction, 32'h0);
        check_eq("noreq_busy", {31'h0, busywait}, 32'h0);

        // Conflict miss: tag 1 evicts tag 0 at index 0
        set_in(1'b1, 10'h080);
        fetch("f8", 6'h08, 1'b0, 10'h0);
        check_eq("f8_w0", instruction, 32'h0000_0800);
        set_in(1'b1, 10'h084);
        check_eq("f8_w1", instruction, 32'h0000_0801);
        set_in(1'b1, 10'h000);
        check_eq("evict_busy", {31'h0, busywait}, 32'h1);
        fetch("f0b", 6'h00, 1'b0, 10'h0);
        check_eq("f0b_w0", instruction, 32'h0);
        check_eq("f0b_busy", {31'h0, busywait}, 32'h0);

        // PC changes mid-fetch; fill still lands at the latched block
        set_in(1'b1, 10'h010);
        fetch("f1", 6'h01, 1'b1, 10'h3F0);
        check_eq("sw_busy", {31'h0, busywait}, 32'h1);
        check_eq("sw_mrd", {31'h0, mem_read}, 32'h0);
        fetch("f3f", 6'h3F, 1'b0, 10'h0);
        check_eq("f3f_w0", instruction, 32'h0000_3F00);
        set_in(1'b1, 10'h014);
        check_eq("f1_w1", instruction, 32'h0000_0101);
        check_eq("f1_busy", {31'h0, busywait}, 32'h0);

        // Reset during the 3rd MEM_READ cycle
        set_in(1'b1, 10'h020);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("mid_mrd", {31'h0, mem_read}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        pc_addr = 10'h000;
        #1;
        check_eq("postrst_mrd", {31'h0, mem_read}, 32'h0);
        check_eq("postrst_miss", {31'h0, busywait}, 32'h1);
        check_eq("postrst_instr", instruction, 32'h0);
        fetch("fr0", 6'h00, 1'b0, 10'h0);
        set_in(1'b1, 10'h020);
        check_eq("postrst_miss2", {31'h0, busywait}, 32'h1);
        fetch("fr2", 6'h02, 1'b0, 10'h0);
        check_eq("fr2_w0", instruction, 32'h0000_0200);

`ifdef ICACHE_STATS_EN
        do_reset();
        check_eq("st_hit0", {16'h0, hit_count}, 32'h0);
        check_eq("st_miss0", {16'h0, miss_count}, 32'h0);
        set_in(1'b1, 10'h030);
        fetch("fs", 6'h03, 1'b0, 10'h0);
        set_in(1'b1, 10'h034);
        set_in(1'b1, 10'h038);
        set_in(1'b1, 10'h03C);
        set_in(1'b0, 10'h000);
        check_eq("st_hit4", {16'h0, hit_count}, 32'd4);
        check_eq("st_miss1", {16'h0, miss_count}, 32'd1);
        do_reset();
        check_eq("st_hitclr", {16'h0, hit_count}, 32'h0);
        check_eq("st_missclr", {16'h0, miss_count}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
